vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/sync_delay_line.sv | 33 +++
 rtl/vga_timing_gen.sv | 102 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants and decode helper
package vga_timing_pkg;

  localparam int unsigned COORD_W    = 10;
  localparam int unsigned FRAME_W    = 16;

  localparam int unsigned H_VISIBLE  = 640;
  localparam int unsigned H_FP       = 16;
  localparam int unsigned H_SYNC     = 96;
  localparam int unsigned H_BP       = 48;
  localparam int unsigned V_VISIBLE  = 480;
  localparam int unsigned V_FP       = 10;
  localparam int unsigned V_SYNC     = 2;
  localparam int unsigned V_BP       = 33;
  localparam int unsigned SYNC_DELAY = 2;

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  // Inclusive range test; an empty range (hi < lo) never matches.
  function automatic logic in_range(input logic [COORD_W-1:0] v,
                                    input logic [COORD_W-1:0] lo,
                                    input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - reset-to-ones shift register, depth 0 is a wire
module sync_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = clk_i ^ rst_ni;
      assign data_o = data_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '1;
        end else begin
          stage_q[0] <= data_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign data_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, registered decodes and delayed sync
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FP       = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP       = vga_timing_pkg::H_BP,
  parameter int unsigned V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FP       = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP       = vga_timing_pkg::V_BP,
  parameter int unsigned SYNC_DELAY = vga_timing_pkg::SYNC_DELAY
) (
  input  logic                                vga_clk,
  input  logic                                reset_n,
  output logic [vga_timing_pkg::COORD_W-1:0]  DrawX,
  output logic [vga_timing_pkg::COORD_W-1:0]  DrawY,
  output logic                                blank,
  output logic                                line_start,
  output logic                                frame_start,
  output logic [vga_timing_pkg::FRAME_W-1:0]  frame_count,
  output logic                                hs,
  output logic                                vs
);
  import vga_timing_pkg::*;

  localparam int unsigned H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] HS_LO  = COORD_W'(H_VISIBLE + H_FP);
  localparam logic [COORD_W-1:0] HS_HI  = COORD_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_LO  = COORD_W'(V_VISIBLE + V_FP);
  localparam logic [COORD_W-1:0] VS_HI  = COORD_W'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               blank_q, blank_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;
  logic               hs_raw_q, hs_raw_d, vs_raw_q, vs_raw_d;

  // Decodes look at the next counter value so the registered flags line up
  // with the DrawX/DrawY they describe.
  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end
    blank_d       = (x_d < H_VIS) && (y_d < V_VIS);
    line_start_d  = (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);
    frame_count_d = frame_count_q + FRAME_W'(frame_start_d);
    hs_raw_d      = !in_range(x_d, HS_LO, HS_HI);
    vs_raw_d      = !in_range(y_d, VS_LO, VS_HI);
  end

  // Reset parks on the last back-porch position so the first edge lands on (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      hs_raw_q      <= 1'b1;
      vs_raw_q      <= 1'b1;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
    end
  end

  sync_delay_line #(
    .DEPTH (SYNC_DELAY),
    .WIDTH (2)
  ) u_sync_delay (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .data_i ({hs_raw_q, vs_raw_q}),
    .data_o ({hs, vs})
  );

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule
